// File: rtl/fp_pkg.sv
// Shared FP encodings: operand classes, result constants, flag bit positions.
// Latency: n/a (types, constants and a pure classification function only).
// Backpressure: n/a.
//   Used by the multiply post-stage and the adder path rounding logic.
package fp_pkg;

  // Operand class encoding delivered alongside each operand.
  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;  // zero, and denormals flushed to zero
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // binary32 constants.
  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}.
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  // Outcome forced by the operand classes, independent of the product bits.
  typedef enum logic [2:0] {
    SP_NONE     = 3'd0,  // both normal: use the computed product
    SP_QNAN     = 3'd1,  // NaN operand: quiet NaN, no flag
    SP_QNAN_INV = 3'd2,  // inf x zero: quiet NaN, invalid
    SP_INF      = 3'd3,  // signed infinity
    SP_ZERO     = 3'd4   // signed zero
  } special_e;

  // Priority: NaN, inf x zero, inf, zero.
  function automatic special_e classify(input logic [1:0] cls_a, input logic [1:0] cls_b);
    if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
      return SP_QNAN;
    end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      return SP_QNAN_INV;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      return SP_INF;
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      return SP_ZERO;
    end
    return SP_NONE;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised fraction with guard/sticky; exponent bumped on carry.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no state.
//   frac_in/guard/sticky/exp_in -> frac_out/exp_out (exponent already incremented on
//   fraction carry-out) and inexact = guard | sticky. Range checks are left to the caller.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0]        frac_in,
  input  logic                    guard,
  input  logic                    sticky,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic [MAN_W-1:0]        frac_out,
  output logic signed [EXP_W+1:0] exp_out,
  output logic                    inexact
);

  logic           round_up;
  logic [MAN_W:0] frac_sum;

  // Ties go to the even fraction: only round up on a tie when the LSB is odd.
  assign round_up = guard & (sticky | frac_in[0]);
  assign frac_sum = {1'b0, frac_in} + {{MAN_W{1'b0}}, round_up};

  // On carry-out the fraction wraps to zero, which is exactly 1.0 x 2^(e+1).
  assign frac_out = frac_sum[MAN_W-1:0];
  assign exp_out  = exp_in + {{(EXP_W+1){1'b0}}, frac_sum[MAN_W]};
  assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_mul_norm_round.sv
// FP multiply post-stage: normalise 2*(MAN_W+1)-bit product, round RNE, specials, binary32 out.
// Latency: 2 cycles from accepted input beat to out_valid; 1 beat/cycle when out_ready=1.
// Backpressure: valid/ready per stage; in_ready = !s1_valid || stage 2 can load; output held while stalled.
//   Ports: clk, rst (sync, active-high); in_valid/in_ready, in_prod, in_exp_a/b, in_sign,
//   in_cls_a/b; out_valid/out_ready, out_res (binary32), out_flags {invalid,ovf,unf,inexact}.
module fp_mul_norm_round #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int BIAS   = fp_pkg::BIAS,
  parameter int PROD_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PROD_W-1:0]      in_prod,
  input  logic [EXP_W-1:0]       in_exp_a,
  input  logic [EXP_W-1:0]       in_exp_b,
  input  logic                   in_sign,
  input  logic [1:0]             in_cls_a,
  input  logic [1:0]             in_cls_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [3:0]             out_flags
);

  import fp_pkg::*;

  // Product of two 1.f significands lies in [1,4): bit TOP set means the value is >= 2.
  localparam int TOP = 2*MAN_W + 1;
  localparam int EW  = EXP_W + 2;
  localparam int RW  = 1 + EXP_W + MAN_W;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [RW-1:0]        QNAN_R = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Product bits above the significant field carry nothing for this path.
  logic unused_prod_hi;
  assign unused_prod_hi = ^in_prod[PROD_W-1:TOP+1];

  // ---------------- stage 1 state ----------------
  logic                 s1_valid;
  logic [MAN_W-1:0]     s1_frac;
  logic                 s1_guard;
  logic                 s1_sticky;
  logic signed [EW-1:0] s1_exp;
  logic                 s1_sign;
  special_e             s1_spec;

  // ---------------- handshake ----------------
  logic s2_can_load;
  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;

  // ---------------- stage 1 normalise ----------------
  logic signed [EW-1:0] e_sum;
  logic [MAN_W-1:0]     n_frac;
  logic                 n_guard;
  logic                 n_sticky;
  logic signed [EW-1:0] n_exp;

  // Two extra exponent bits keep both the exp_a+exp_b overflow and the negative
  // underflow range representable until stage 2 decides.
  assign e_sum = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - BIAS_E;

  always_comb begin
    n_frac   = '0;
    n_guard  = 1'b0;
    n_sticky = 1'b0;
    n_exp    = e_sum;
    if (in_prod[TOP]) begin
      n_frac   = in_prod[TOP-1 -: MAN_W];
      n_guard  = in_prod[TOP-1-MAN_W];
      n_sticky = |in_prod[TOP-2-MAN_W:0];
      n_exp    = e_sum + ONE_E;
    end else begin
      n_frac   = in_prod[TOP-2 -: MAN_W];
      n_guard  = in_prod[TOP-2-MAN_W];
      n_sticky = |in_prod[TOP-3-MAN_W:0];
    end
  end

  // ---------------- stage 2 round + pack ----------------
  logic [MAN_W-1:0]     r_frac;
  logic signed [EW-1:0] r_exp;
  logic                 r_inexact;
  logic [RW-1:0]        res_d;
  logic [3:0]           flags_d;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .frac_in  (s1_frac),
    .guard    (s1_guard),
    .sticky   (s1_sticky),
    .exp_in   (s1_exp),
    .frac_out (r_frac),
    .exp_out  (r_exp),
    .inexact  (r_inexact)
  );

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (s1_spec)
      SP_QNAN: begin
        res_d = QNAN_R;
      end
      SP_QNAN_INV: begin
        res_d                 = QNAN_R;
        flags_d[FLAG_INVALID] = 1'b1;
      end
      SP_INF: begin
        res_d = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      SP_ZERO: begin
        res_d = {s1_sign, {(RW-1){1'b0}}};
      end
      default: begin
        if (r_exp >= EMAX_E) begin
          res_d                  = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[FLAG_OVERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]  = 1'b1;
        end else if (r_exp < ONE_E) begin
          // No denormal support: anything below the normal range flushes to zero.
          res_d                   = {s1_sign, {(RW-1){1'b0}}};
          flags_d[FLAG_UNDERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          res_d                 = {s1_sign, r_exp[EXP_W-1:0], r_frac};
          flags_d[FLAG_INEXACT] = r_inexact;
        end
      end
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_frac   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_exp    <= '0;
      s1_sign   <= 1'b0;
      s1_spec   <= SP_NONE;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_frac   <= n_frac;
          s1_guard  <= n_guard;
          s1_sticky <= n_sticky;
          s1_exp    <= n_exp;
          s1_sign   <= in_sign;
          s1_spec   <= classify(in_cls_a, in_cls_b);
        end
      end
      if (s2_can_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_res   <= res_d;
          out_flags <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed literals, backpressure, reset, random.
// Expected results come from an arithmetic model (integer divide/remainder rounding).
// One negedge process compares every valid output against the oldest outstanding beat.
module tb_fp_mul_norm_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_prod;
  logic [7:0]  in_exp_a;
  logic [7:0]  in_exp_b;
  logic        in_sign;
  logic [1:0]  in_cls_a;
  logic [1:0]  in_cls_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  fp_mul_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_exp_a  (in_exp_a),
    .in_exp_b  (in_exp_b),
    .in_sign   (in_sign),
    .in_cls_a  (in_cls_a),
    .in_cls_b  (in_cls_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    logic [63:0] prod;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        s;
    logic [1:0]  ca;
    logic [1:0]  cb;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: significand as an integer, drop the low bits by division, round
  // half-to-even by comparing the remainder with half a unit.
  function automatic exp_t model(input logic [63:0] prod, input logic [7:0] ea,
                                 input logic [7:0] eb, input logic s,
                                 input logic [1:0] ca, input logic [1:0] cb);
    exp_t   r;
    longint m, q, rem, half;
    int     sh, e;
    r.flags = 4'b0000;
    r.res   = 32'h0;
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      r.res = 32'h7FC0_0000;
    end else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
      r.res   = 32'h7FC0_0000;
      r.flags = 4'b1000;
    end else if (ca == CLS_INF || cb == CLS_INF) begin
      r.res = {s, 8'hFF, 23'h0};
    end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
      r.res = {s, 31'h0};
    end else begin
      m    = longint'(prod[47:0]);
      sh   = (m >= (longint'(1) << 47)) ? 24 : 23;
      e    = int'(ea) + int'(eb) - 127 + (sh - 23);
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        r.res   = {s, 8'hFF, 23'h0};
        r.flags = 4'b0101;
      end else if (e <= 0) begin
        r.res   = {s, 31'h0};
        r.flags = 4'b0011;
      end else begin
        r.res   = {s, e[7:0], q[22:0]};
        r.flags = {3'b000, rem != 0};
      end
    end
    return r;
  endfunction

  // Compare process: every output beat that is valid must equal the oldest
  // outstanding expectation, and it is retired when the transfer happens.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_out_valid");
        end else begin
          e = exp_q[0];
          chk("model_res", out_res, e.res);
          chk("model_flags", {28'h0, out_flags}, {28'h0, e.flags});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_prod, in_exp_a, in_exp_b, in_sign, in_cls_a, in_cls_b));
    end
  end

  task automatic drive(input vec_t v);
    in_prod  = v.prod;
    in_exp_a = v.ea;
    in_exp_b = v.eb;
    in_sign  = v.s;
    in_cls_a = v.ca;
    in_cls_b = v.cb;
  endtask

  // Present one beat and hold it until accepted; returns just after the accept edge.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    in_valid = 1'b1;
    drive(v);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), compare against literals, count negedges waited.
  task automatic wait_out(input string name, input logic [31:0] res, input logic [3:0] fl,
                          output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < 20);
    if (!out_valid) begin
      fail_now({name, "_timeout"});
    end else begin
      chk({name, "_res"}, out_res, res);
      chk({name, "_flags"}, {28'h0, out_flags}, {28'h0, fl});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t   v;
    longint ma, mb;
    int     t, eb;
    ma     = longint'($urandom_range(32'h0080_0000, 32'h00FF_FFFF));
    mb     = longint'($urandom_range(32'h0080_0000, 32'h00FF_FFFF));
    v.prod = {$urandom_range(0, 32'hFFFF), 48'h0} | 64'(ma * mb);
    v.ea   = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 3))
      0: t = $urandom_range(250, 258);  // around overflow
      1: t = $urandom_range(0, 3);      // around underflow
      default: t = $urandom_range(1, 254);
    endcase
    eb = t + 127 - int'(v.ea);
    if (eb < 0) eb = 0;
    if (eb > 255) eb = 255;
    v.eb = 8'(eb);
    v.s  = 1'($urandom_range(0, 1));
    v.ca = CLS_NORM;
    v.cb = CLS_NORM;
    if ($urandom_range(0, 7) == 0) begin
      v.ca = 2'($urandom_range(0, 3));
      v.cb = 2'($urandom_range(0, 3));
    end
    v.res = 32'h0;
    v.fl  = 4'h0;
    return v;
  endfunction

  vec_t dv[10];
  vec_t bp[4];

  initial begin
    int   waited, nacc, n;
    logic acc;
    vec_t v;

    dv[0] = '{64'h0000_4000_0000_0000, 8'd127, 8'd127, 1'b0, CLS_NORM, CLS_NORM, 32'h3F80_0000, 4'b0000};
    dv[1] = '{64'h0000_9000_0000_0000, 8'd127, 8'd127, 1'b0, CLS_NORM, CLS_NORM, 32'h4010_0000, 4'b0000};
    dv[2] = '{64'h0000_7FFF_FFC0_0000, 8'd127, 8'd127, 1'b0, CLS_NORM, CLS_NORM, 32'h4000_0000, 4'b0001};
    dv[3] = '{64'h0000_4000_0000_0000, 8'd254, 8'd254, 1'b1, CLS_NORM, CLS_NORM, 32'hFF80_0000, 4'b0101};
    dv[4] = '{64'h0000_4000_0000_0000, 8'd200, 8'd3,   1'b0, CLS_INF,  CLS_ZERO, 32'h7FC0_0000, 4'b1000};
    dv[5] = '{64'h0000_4000_0000_0000, 8'd1,   8'd1,   1'b0, CLS_NORM, CLS_NORM, 32'h0000_0000, 4'b0011};
    dv[6] = '{64'hABCD_4000_0040_0000, 8'd127, 8'd127, 1'b0, CLS_NORM, CLS_NORM, 32'h3F80_0000, 4'b0001};
    dv[7] = '{64'h0000_4000_00C0_0000, 8'd127, 8'd127, 1'b0, CLS_NORM, CLS_NORM, 32'h3F80_0002, 4'b0001};
    dv[8] = '{64'h0000_4000_0000_0000, 8'd127, 8'd127, 1'b1, CLS_INF,  CLS_NORM, 32'hFF80_0000, 4'b0000};
    dv[9] = '{64'h0000_4000_0000_0000, 8'd127, 8'd127, 1'b1, CLS_NAN,  CLS_ZERO, 32'h7FC0_0000, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_prod = '0; in_exp_a = '0; in_exp_b = '0; in_sign = 1'b0;
    in_cls_a = CLS_NORM; in_cls_b = CLS_NORM;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_res", out_res, 32'h0);
    chk("rst_out_flags", {28'h0, out_flags}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Directed literals; first one also pins the 2-cycle latency.
    send(dv[0]);
    @(negedge clk);
    chk("lat_not_yet", {31'h0, out_valid}, 32'h0);
    wait_out("one_x_one", dv[0].res, dv[0].fl, waited);
    chk("latency_cycles", waited, 32'd1);
    for (int i = 1; i < 10; i++) begin
      send(dv[i]);
      wait_out($sformatf("dir%0d", i), dv[i].res, dv[i].fl, waited);
    end

    // Backpressure: four beats offered back to back with the sink stalled.
    for (int i = 0; i < 4; i++) begin
      bp[i]      = rand_vec();
      bp[i].ea   = 8'd127;
      bp[i].eb   = 8'd127;
      bp[i].ca   = CLS_NORM;
      bp[i].cb   = CLS_NORM;
    end
    out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (nacc < 4);
      if (nacc < 4) drive(bp[nacc]);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 4) begin
        chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
        chk("bp_accepted", nacc, 32'd2);
        chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      end
      @(posedge clk);
      #1;
      if (acc) nacc++;
    end
    out_ready = 1'b1;
    n = 0;
    while (nacc < 4 && n < 50) begin
      in_valid = 1'b1;
      drive(bp[nacc]);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) nacc++;
      n++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", nacc, 32'd4);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("bp_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Reset with beats in flight and the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive(rand_vec());
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_out_res", out_res, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Random traffic with random stalls on both sides.
    nacc = 0;
    n = 0;
    while (nacc < 2000 && n < 20000) begin
      v = rand_vec();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(v);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) nacc++;
      n++;
    end
    chk("rand_accepted", nacc, 32'd2000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("rand_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
